// File: rtl/plcp_pkg.sv
// PLCP frame builder shared types and constants.
// Rate decode and SIGNAL word construction.
package plcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SIGNAL,
    ST_SERVICE,
    ST_PSDU,
    ST_TAIL,
    ST_PAD,
    ST_DONE
  } state_t;

  localparam int SIGNAL_BITS  = 24;
  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;

  // x^7 + x^4 + 1: taps on s[6] and s[3]
  localparam logic [6:0] SCRAMBLER_POLY = 7'b1001000;

  function automatic logic [7:0] rate_to_ndbps(
    input logic [3:0] rate
  );
    logic [7:0] nd;
    case (rate)
      4'b1101: nd = 8'd24;
      4'b1111: nd = 8'd36;
      4'b0101: nd = 8'd48;
      4'b0111: nd = 8'd72;
      4'b1001: nd = 8'd96;
      4'b1011: nd = 8'd144;
      4'b0001: nd = 8'd192;
      4'b0011: nd = 8'd216;
      default: nd = 8'd0;
    endcase
    return nd;
  endfunction

  // Bit 23 leaves first: R1..R4, reserved, LENGTH lsb-first,
  // even parity, six tail zeros.
  function automatic logic [23:0] build_signal(
    input logic [3:0]  rate,
    input logic [11:0] length
  );
    logic [16:0] head;
    head[16:13] = rate;
    head[12]    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      head[11-i] = length[i];
    end
    return {head, ^head, 6'b000000};
  endfunction

endpackage

// File: rtl/plcp_frame_builder_if.sv
// Control, PSDU handshake and frame stream bundle
// between the TX controller and the frame builder.
interface plcp_frame_builder_if;

  logic        Start;
  logic [3:0]  Rate;
  logic [11:0] Length;
  logic        DataIn;
  logic        DataValid;
  logic        DataReady;
  logic        Output;
  logic        OutputValid;
  logic        Busy;
  logic        Done;
  logic        Error;

  modport master (
    output Start,
    output Rate,
    output Length,
    output DataIn,
    output DataValid,
    input  DataReady,
    input  Output,
    input  OutputValid,
    input  Busy,
    input  Done,
    input  Error
  );

  modport slave (
    input  Start,
    input  Rate,
    input  Length,
    input  DataIn,
    input  DataValid,
    output DataReady,
    output Output,
    output OutputValid,
    output Busy,
    output Done,
    output Error
  );

endinterface

// File: rtl/plcp_scrambler.sv
// Frame-synchronous 7-bit additive scrambler.
// Out is combinational; state steps on Enable.
module plcp_scrambler #(
  parameter logic [6:0] SEED = 7'b1011101
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Load,
  input  logic Enable,
  input  logic In,
  output logic Out
);

  import plcp_pkg::*;

  logic [6:0] lfsr;
  logic       fb;

  assign fb  = ^(lfsr & SCRAMBLER_POLY);
  assign Out = In ^ fb;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lfsr <= 7'd0;
    end else if (Load) begin
      lfsr <= SEED;
    end else if (Enable) begin
      lfsr <= {lfsr[5:0], fb};
    end
  end

endmodule

// File: rtl/plcp_frame_builder.sv
// Serial 802.11a PPDU generator: preamble, SIGNAL,
// SERVICE, PSDU, tail and pad into the conv encoder.
module plcp_frame_builder #(
  parameter int unsigned PREAMBLE_BITS    = 96,
  parameter logic [7:0]  PREAMBLE_PATTERN = 8'hAA,
  parameter logic [6:0]  SCRAMBLER_SEED   = 7'b1011101
) (
  input logic              Clock,
  input logic              Reset,
  plcp_frame_builder_if.slave bus
);

  import plcp_pkg::*;

  state_t      state;
  logic [14:0] cnt;
  logic [7:0]  mod_cnt;
  logic [7:0]  mod_nxt;
  logic [7:0]  ndbps;
  logic [7:0]  start_ndbps;
  logic [11:0] len;
  logic [23:0] sig;

  logic out_q;
  logic valid_q;
  logic ready_q;
  logic busy_q;
  logic done_q;
  logic error_q;

  logic scr_load;
  logic scr_en;
  logic scr_in;
  logic scr_out;
  logic psdu_last;

  assign bus.Output      = out_q;
  assign bus.OutputValid = valid_q;
  assign bus.DataReady   = ready_q;
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Error       = error_q;

  always_comb begin
    start_ndbps = rate_to_ndbps(bus.Rate);
    mod_nxt = (mod_cnt == ndbps - 8'd1)
            ? 8'd0 : mod_cnt + 8'd1;
    psdu_last = (cnt == {len, 3'b000} - 15'd1);
    scr_load = (state == ST_SIGNAL)
            && (cnt == 15'(SIGNAL_BITS - 1));
    scr_in = (state == ST_PSDU) && bus.DataIn;
    scr_en = (state == ST_SERVICE)
          || (state == ST_TAIL)
          || (state == ST_PAD)
          || ((state == ST_PSDU) && bus.DataValid);
  end

  plcp_scrambler #(
    .SEED (SCRAMBLER_SEED)
  ) u_scr (
    .Clock  (Clock),
    .Reset  (Reset),
    .Load   (scr_load),
    .Enable (scr_en),
    .In     (scr_in),
    .Out    (scr_out)
  );

  // state/cnt name the bit to be registered at the next edge
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      cnt     <= 15'd0;
      mod_cnt <= 8'd0;
      ndbps   <= 8'd0;
      len     <= 12'd0;
      sig     <= 24'd0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          if (bus.Start) begin
            if (start_ndbps == 8'd0
                || bus.Length == 12'd0) begin
              error_q <= 1'b1;
            end else begin
              state   <= ST_PREAMBLE;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              out_q   <= PREAMBLE_PATTERN[7];
              cnt     <= 15'd1;
              mod_cnt <= 8'd0;
              ndbps   <= start_ndbps;
              len     <= bus.Length;
              sig     <= build_signal(bus.Rate,
                                      bus.Length);
            end
          end
        end
        ST_PREAMBLE: begin
          out_q <= PREAMBLE_PATTERN[~cnt[2:0]];
          cnt   <= cnt + 15'd1;
          if (cnt == 15'(PREAMBLE_BITS - 1)) begin
            state <= ST_SIGNAL;
            cnt   <= 15'd0;
          end
        end
        ST_SIGNAL: begin
          out_q <= sig[23];
          sig   <= {sig[22:0], 1'b0};
          cnt   <= cnt + 15'd1;
          if (scr_load) begin
            state <= ST_SERVICE;
            cnt   <= 15'd0;
          end
        end
        ST_SERVICE: begin
          out_q   <= scr_out;
          mod_cnt <= mod_nxt;
          cnt     <= cnt + 15'd1;
          if (cnt == 15'(SERVICE_BITS - 1)) begin
            state   <= ST_PSDU;
            cnt     <= 15'd0;
            ready_q <= 1'b1;
          end
        end
        ST_PSDU: begin
          valid_q <= bus.DataValid;
          if (bus.DataValid) begin
            out_q   <= scr_out;
            mod_cnt <= mod_nxt;
            cnt     <= cnt + 15'd1;
            if (psdu_last) begin
              state   <= ST_TAIL;
              cnt     <= 15'd0;
              ready_q <= 1'b0;
            end
          end
        end
        ST_TAIL: begin
          out_q   <= 1'b0;
          mod_cnt <= mod_nxt;
          cnt     <= cnt + 15'd1;
          if (cnt == 15'(TAIL_BITS - 1)) begin
            cnt <= 15'd0;
            if (mod_nxt == 8'd0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          out_q   <= scr_out;
          mod_cnt <= mod_nxt;
          if (mod_nxt == 8'd0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt     <= 15'd0;
          mod_cnt <= 8'd0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plcp_frame_builder.sv
// Directed bench for plcp_frame_builder with an
// independent bit-level PPDU reference model.
module tb_plcp_frame_builder;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  always #5 Clock = ~Clock;

  plcp_frame_builder_if bus ();

  plcp_frame_builder dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic psdu [0:1023];
  logic got  [0:1023];
  logic expv [0:1023];
  logic ref1 [0:1023];

  int   got_n, exp_n, cycles;
  int   idle_cycles, ready_cycles;
  int   done_cnt, err_seen;
  logic done_ok, finished;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  function automatic int count_diff();
    int d;
    d = (got_n > exp_n) ? got_n - exp_n
                        : exp_n - got_n;
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      if (got[i] !== expv[i]) d++;
    end
    return d;
  endfunction

  task automatic build_expected(
    input logic [3:0]  rate,
    input logic [11:0] len
  );
    int         nd, nd_bits, dcount;
    logic [6:0] s;
    logic       fb, din, par;
    case (rate)
      4'b1101: nd = 24;
      4'b1111: nd = 36;
      4'b0101: nd = 48;
      4'b0111: nd = 72;
      4'b1001: nd = 96;
      4'b1011: nd = 144;
      4'b0001: nd = 192;
      4'b0011: nd = 216;
      default: nd = 1;
    endcase
    exp_n = 0;
    for (int i = 0; i < 96; i++) begin
      expv[exp_n] = ((i % 2) == 0);
      exp_n++;
    end
    par = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      expv[exp_n] = rate[i];
      par ^= rate[i];
      exp_n++;
    end
    expv[exp_n] = 1'b0;
    exp_n++;
    for (int i = 0; i < 12; i++) begin
      expv[exp_n] = len[i];
      par ^= len[i];
      exp_n++;
    end
    expv[exp_n] = par;
    exp_n++;
    for (int i = 0; i < 6; i++) begin
      expv[exp_n] = 1'b0;
      exp_n++;
    end
    s       = 7'b1011101;
    nd_bits = 16 + 8 * int'(len) + 6;
    dcount  = 0;
    while (dcount < nd_bits || (dcount % nd) != 0) begin
      if (dcount >= 16 && dcount < nd_bits - 6)
        din = psdu[dcount-16];
      else
        din = 1'b0;
      fb = s[6] ^ s[3];
      s  = {s[5:0], fb};
      if (dcount >= nd_bits - 6 && dcount < nd_bits)
        expv[exp_n] = 1'b0;
      else
        expv[exp_n] = din ^ fb;
      exp_n++;
      dcount++;
    end
  endtask

  task automatic run_frame(
    input logic [3:0]  rate,
    input logic [11:0] len,
    input int          stall_at,
    input int          stall_len,
    input int          reset_at,
    input bit          spam
  );
    int k, stall_left;
    k = 0;
    stall_left   = stall_len;
    got_n        = 0;
    cycles       = 0;
    idle_cycles  = 0;
    ready_cycles = 0;
    done_cnt     = 0;
    err_seen     = 0;
    done_ok      = 1'b0;
    finished     = 1'b0;
    bus.Rate   = rate;
    bus.Length = len;
    bus.Start  = 1'b1;
    @(negedge Clock);
    bus.Start  = 1'b0;
    bus.Rate   = 4'b0000;
    bus.Length = 12'd7;
    for (int c = 0; c < 2000 && !finished; c++) begin
      cycles++;
      if (bus.OutputValid) begin
        got[got_n] = bus.Output;
        got_n++;
      end else if (bus.Busy) begin
        idle_cycles++;
      end
      if (bus.DataReady) ready_cycles++;
      if (bus.Error) err_seen++;
      if (bus.Done) begin
        done_cnt++;
        done_ok  = bus.OutputValid;
        finished = 1'b1;
      end else if (reset_at >= 0
                   && got_n == reset_at + 1) begin
        bus.Start = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        check_eq("reset_mid_frame",
                 {bus.Output, bus.OutputValid,
                  bus.DataReady, bus.Busy,
                  bus.Done, bus.Error}, 32'd0);
        Reset = 1'b0;
        return;
      end else begin
        bus.Start = spam && (c == 50 || c == 200);
        if (bus.DataReady) begin
          if (k == stall_at && stall_left > 0) begin
            bus.DataValid = 1'b0;
            stall_left--;
          end else begin
            bus.DataValid = 1'b1;
            bus.DataIn    = psdu[k];
            k++;
          end
        end else begin
          bus.DataValid = 1'b1;
          bus.DataIn    = 1'b0;
        end
        @(negedge Clock);
      end
    end
    bus.Start = 1'b0;
    check_eq("frame_end", 32'(finished), 32'd1);
    @(negedge Clock);
    check_eq("idle_after_done",
             {bus.Busy, bus.OutputValid,
              bus.Done, bus.DataReady}, 32'd0);
  endtask

  task automatic check_reject(
    input string       tag,
    input logic [3:0]  rate,
    input logic [11:0] len
  );
    logic e1, e2, act;
    bus.Rate   = rate;
    bus.Length = len;
    bus.Start  = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0;
    e1  = bus.Error;
    act = bus.Busy | bus.OutputValid | bus.DataReady;
    @(negedge Clock);
    e2  = bus.Error;
    act = act | bus.Busy | bus.OutputValid
        | bus.DataReady;
    check_eq({tag, "_err"}, {e1, e2}, 32'b10);
    check_eq({tag, "_quiet"}, 32'(act), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] w;
    logic [6:0]  f7;
    logic [5:0]  tl;
    int          d;
    bus.Start     = 1'b0;
    bus.Rate      = 4'd0;
    bus.Length    = 12'd0;
    bus.DataIn    = 1'b0;
    bus.DataValid = 1'b0;
    repeat (3) @(negedge Clock);
    check_eq("reset_state",
             {bus.Output, bus.OutputValid,
              bus.DataReady, bus.Busy,
              bus.Done, bus.Error}, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 1024; i++)
      psdu[i] = ((i % 3) == 0) ^ ((i % 7) == 2);

    // 6 Mb/s, 16 octets
    build_expected(4'b1101, 12'd16);
    run_frame(4'b1101, 12'd16, -1, 0, -1, 1'b0);
    check_eq("s1_valid_bits", got_n, 288);
    check_eq("s1_cycles", cycles, 288);
    check_eq("s1_ready_cycles", ready_cycles, 128);
    check_eq("s1_done_count", done_cnt, 1);
    check_eq("s1_done_on_last", 32'(done_ok), 1);
    check_eq("s1_gaps", idle_cycles, 0);
    check_eq("s1_errors", err_seen, 0);
    check_eq("s1_model_diff", count_diff(), 0);
    for (int i = 0; i < 24; i++) w[23-i] = got[96+i];
    check_eq("s1_signal", w,
             24'b110100000100000000000000);
    for (int i = 0; i < 1024; i++) ref1[i] = got[i];

    // 54 Mb/s, 1 octet: 30 data + 186 pad
    build_expected(4'b0011, 12'd1);
    run_frame(4'b0011, 12'd1, -1, 0, -1, 1'b0);
    check_eq("s2_data_field", got_n - 120, 216);
    check_eq("s2_model_diff", count_diff(), 0);

    check_reject("bad_rate", 4'b0000, 12'd5);
    check_reject("zero_len", 4'b1101, 12'd0);

    // PSDU stall of 5 cycles at bit 40
    build_expected(4'b1101, 12'd16);
    run_frame(4'b1101, 12'd16, 40, 5, -1, 1'b0);
    check_eq("s4_valid_bits", got_n, 288);
    check_eq("s4_cycles", cycles, 293);
    check_eq("s4_gaps", idle_cycles, 5);
    check_eq("s4_ready_cycles", ready_cycles, 133);
    d = 0;
    for (int i = 0; i < 288; i++)
      if (got[i] !== ref1[i]) d++;
    check_eq("s4_same_as_s1", d, 0);

    // all-zero PSDU exposes the raw LFSR sequence
    for (int i = 0; i < 1024; i++) psdu[i] = 1'b0;
    build_expected(4'b1101, 12'd16);
    run_frame(4'b1101, 12'd16, -1, 0, -1, 1'b0);
    check_eq("s5_model_diff", count_diff(), 0);
    for (int i = 0; i < 7; i++) f7[6-i] = got[120+i];
    check_eq("s5_first7", f7, 7'b0110110);
    d = 0;
    for (int i = 0; i < 17; i++)
      if (got[120+i] !== got[247+i]) d++;
    check_eq("s5_period127", d, 0);
    for (int i = 0; i < 6; i++) tl[i] = got[264+i];
    check_eq("s5_tail", tl, 6'd0);

    // reset at SIGNAL bit 10, then a clean frame
    for (int i = 0; i < 1024; i++)
      psdu[i] = ((i % 3) == 0) ^ ((i % 7) == 2);
    run_frame(4'b1101, 12'd16, -1, 0, 106, 1'b0);
    build_expected(4'b1101, 12'd16);
    run_frame(4'b1101, 12'd16, -1, 0, -1, 1'b1);
    check_eq("s6_valid_bits", got_n, 288);
    check_eq("s6_cycles", cycles, 288);
    check_eq("s6_errors", err_seen, 0);
    check_eq("s6_model_diff", count_diff(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
